// File: rtl/reg_write_arbiter_if.sv
// Write-path bundle between requesting masters and the register-write arbiter.
// Requester side: req (level), packed req_addr / req_data (requester k at
// [k*AW +: AW] / [k*WIDTH +: WIDTH]).
// Arbiter side: ack / err one-cycle pulses per requester, one-hot wr_en and
// shared wr_data toward the register bank, grant_id (debug) and busy.
interface reg_write_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NREG  = 8,
  parameter int WIDTH = 4,
  parameter int AW    = 3,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       err;
  logic [NREG-1:0]       wr_en;
  logic [WIDTH-1:0]      wr_data;
  logic [IDW-1:0]        grant_id;
  logic                  busy;

  // Requester / bank side.
  modport master (
    output req, req_addr, req_data,
    input  ack, err, wr_en, wr_data, grant_id, busy
  );

  // Arbiter side.
  modport slave (
    input  req, req_addr, req_data,
    output ack, err, wr_en, wr_data, grant_id, busy
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one write path into a bank of enable-loaded
// registers. Each cycle at most one eligible requester wins; its address is
// decoded into a one-hot wr_en, its data is driven on wr_data and it receives
// a one-cycle ack (or err when the address is outside the bank).
// Ports:
//   clk   - rising-edge clock
//   rstn  - asynchronous active-low reset
//   bus   - reg_write_arbiter_if slave modport (req/req_addr/req_data in;
//           ack/err/wr_en/wr_data/grant_id/busy out, all registered)
module reg_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int NREG  = 8,
  parameter int WIDTH = 4,
  parameter int AW    = 3,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  reg_write_arbiter_if.slave   bus
);

  logic [NREQ-1:0]  ack_q;
  logic [NREQ-1:0]  err_q;
  logic [NREG-1:0]  wr_en_q;
  logic [WIDTH-1:0] wr_data_q;
  logic [IDW-1:0]   grant_id_q;
  logic             busy_q;
  logic [IDW-1:0]   rr_ptr;

  logic [NREQ-1:0]  elig;
  logic             found;
  int               win;
  logic [NREQ-1:0]  win_onehot;
  logic [AW-1:0]    win_addr;
  logic [WIDTH-1:0] win_data;
  logic             addr_ok;

  function automatic logic [NREG-1:0] decode(input logic [AW-1:0] a);
    logic [NREG-1:0] dec;
    dec = '0;
    for (int r = 0; r < NREG; r++) begin
      dec[r] = (a == AW'(r));
    end
    return dec;
  endfunction

  // A requester that holds ack or err this cycle sits out the next grant, so
  // it can drop req on seeing ack without being written twice.
  always_comb begin
    elig       = bus.req & ~ack_q & ~err_q;
    found      = 1'b0;
    win        = 0;
    win_onehot = '0;
    win_addr   = '0;
    win_data   = '0;
    begin
      int best_d;
      int d;
      best_d = NREQ;
      // Pick the eligible requester closest to rr_ptr going upward (mod NREQ).
      for (int k = 0; k < NREQ; k++) begin
        d = k - int'(rr_ptr);
        if (d < 0) d = d + NREQ;
        if (elig[k] && d < best_d) begin
          best_d        = d;
          found         = 1'b1;
          win           = k;
          win_onehot    = '0;
          win_onehot[k] = 1'b1;
          win_addr      = bus.req_addr[k*AW +: AW];
          win_data      = bus.req_data[k*WIDTH +: WIDTH];
        end
      end
    end
    addr_ok = int'(win_addr) < NREG;
  end

  // Grant stage: all outputs registered here; reset clears the pending write
  // at once so no partial write reaches the bank.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_q      <= '0;
      err_q      <= '0;
      wr_en_q    <= '0;
      wr_data_q  <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      rr_ptr     <= '0;
    end else if (found) begin
      busy_q     <= 1'b1;
      grant_id_q <= IDW'(win);
      rr_ptr     <= (win == NREQ - 1) ? '0 : IDW'(win + 1);
      if (addr_ok) begin
        wr_en_q   <= decode(win_addr);
        wr_data_q <= win_data;
        ack_q     <= win_onehot;
        err_q     <= '0;
      end else begin
        wr_en_q   <= '0;
        ack_q     <= '0;
        err_q     <= win_onehot;
      end
    end else begin
      ack_q   <= '0;
      err_q   <= '0;
      wr_en_q <= '0;
      busy_q  <= 1'b0;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter (NREQ=4, NREG=6, WIDTH=4, AW=3).
// Table of directed vectors plus hand-written drop-on-ack and mid-stream
// reset sequences.
module tb_reg_write_arbiter;
  localparam int NREQ  = 4;
  localparam int NREG  = 6;
  localparam int WIDTH = 4;
  localparam int AW    = 3;
  localparam int IDW   = 2;

  // Addresses {req3,req2,req1,req0} = {0,5,1,3}; bad variant has req2 at 7.
  localparam logic [11:0] ADDR_N   = 12'h14B;
  localparam logic [11:0] ADDR_BAD = 12'h1CB;
  // Data {req3,req2,req1,req0} = {3,C,5,A}.
  localparam logic [15:0] DATA_N   = 16'h3C5A;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  reg_write_arbiter_if #(.NREQ(NREQ), .NREG(NREG), .WIDTH(WIDTH), .AW(AW), .IDW(IDW)) bus ();

  reg_write_arbiter #(.NREQ(NREQ), .NREG(NREG), .WIDTH(WIDTH), .AW(AW), .IDW(IDW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [11:0] addr;
    logic [15:0] data;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [5:0]  wr_en;
    logic [3:0]  wr_data;
    logic [1:0]  gid;
    logic        busy;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] ack, input logic [3:0] err,
                            input logic [5:0] wr_en, input logic [3:0] wr_data,
                            input logic [1:0] gid, input logic busy);
    chk({tag, ".ack"},      32'(bus.ack),      32'(ack));
    chk({tag, ".err"},      32'(bus.err),      32'(err));
    chk({tag, ".wr_en"},    32'(bus.wr_en),    32'(wr_en));
    chk({tag, ".wr_data"},  32'(bus.wr_data),  32'(wr_data));
    chk({tag, ".grant_id"}, 32'(bus.grant_id), 32'(gid));
    chk({tag, ".busy"},     32'(bus.busy),     32'(busy));
    chk({tag, ".inv_wr_en_onehot0"},  32'($onehot0(bus.wr_en)), 32'd1);
    chk({tag, ".inv_ackerr_onehot0"}, 32'($onehot0(bus.ack | bus.err)), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [11:0] a, input logic [15:0] d);
    bus.req      = r;
    bus.req_addr = a;
    bus.req_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    drive(4'b0000, ADDR_N, DATA_N);

    //          req      addr      data      ack      err      wr_en      wdat  gid   busy
    vecs[0]  = '{4'b0001, ADDR_N,   DATA_N,   4'b0001, 4'b0000, 6'b001000, 4'hA, 2'd0, 1'b1};
    vecs[1]  = '{4'b0001, ADDR_N,   DATA_N,   4'b0000, 4'b0000, 6'b000000, 4'hA, 2'd0, 1'b0};
    vecs[2]  = '{4'b0001, ADDR_N,   DATA_N,   4'b0001, 4'b0000, 6'b001000, 4'hA, 2'd0, 1'b1};
    vecs[3]  = '{4'b0000, ADDR_N,   DATA_N,   4'b0000, 4'b0000, 6'b000000, 4'hA, 2'd0, 1'b0};
    vecs[4]  = '{4'b1000, ADDR_N,   DATA_N,   4'b1000, 4'b0000, 6'b000001, 4'h3, 2'd3, 1'b1};
    vecs[5]  = '{4'b0000, ADDR_N,   DATA_N,   4'b0000, 4'b0000, 6'b000000, 4'h3, 2'd3, 1'b0};
    vecs[6]  = '{4'b1111, ADDR_N,   DATA_N,   4'b0001, 4'b0000, 6'b001000, 4'hA, 2'd0, 1'b1};
    vecs[7]  = '{4'b1111, ADDR_N,   DATA_N,   4'b0010, 4'b0000, 6'b000010, 4'h5, 2'd1, 1'b1};
    vecs[8]  = '{4'b1111, ADDR_N,   DATA_N,   4'b0100, 4'b0000, 6'b100000, 4'hC, 2'd2, 1'b1};
    vecs[9]  = '{4'b1111, ADDR_N,   DATA_N,   4'b1000, 4'b0000, 6'b000001, 4'h3, 2'd3, 1'b1};
    vecs[10] = '{4'b1111, ADDR_N,   DATA_N,   4'b0001, 4'b0000, 6'b001000, 4'hA, 2'd0, 1'b1};
    vecs[11] = '{4'b1111, ADDR_N,   DATA_N,   4'b0010, 4'b0000, 6'b000010, 4'h5, 2'd1, 1'b1};
    vecs[12] = '{4'b0000, ADDR_N,   DATA_N,   4'b0000, 4'b0000, 6'b000000, 4'h5, 2'd1, 1'b0};
    vecs[13] = '{4'b0100, ADDR_BAD, 16'hFFFF, 4'b0000, 4'b0100, 6'b000000, 4'h5, 2'd2, 1'b1};
    vecs[14] = '{4'b1001, ADDR_N,   DATA_N,   4'b1000, 4'b0000, 6'b000001, 4'h3, 2'd3, 1'b1};
    vecs[15] = '{4'b1001, ADDR_N,   DATA_N,   4'b0001, 4'b0000, 6'b001000, 4'hA, 2'd0, 1'b1};
    vecs[16] = '{4'b0000, ADDR_N,   DATA_N,   4'b0000, 4'b0000, 6'b000000, 4'hA, 2'd0, 1'b0};
    vecs[17] = '{4'b1111, ADDR_N,   DATA_N,   4'b0010, 4'b0000, 6'b000010, 4'h5, 2'd1, 1'b1};
    vecs[18] = '{4'b0000, ADDR_N,   DATA_N,   4'b0000, 4'b0000, 6'b000000, 4'h5, 2'd1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 4'b0000, 4'b0000, 6'b000000, 4'h0, 2'd0, 1'b0);
    rstn = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].req, vecs[i].addr, vecs[i].data);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].ack, vecs[i].err, vecs[i].wr_en,
                 vecs[i].wr_data, vecs[i].gid, vecs[i].busy);
    end

    // Requester 0 drops req on its ack while requester 2 arrives.
    drive(4'b0001, ADDR_N, DATA_N);
    step();
    check_outs("drop_a", 4'b0001, 4'b0000, 6'b001000, 4'hA, 2'd0, 1'b1);
    drive(4'b0100, ADDR_N, DATA_N);
    step();
    check_outs("drop_b", 4'b0100, 4'b0000, 6'b100000, 4'hC, 2'd2, 1'b1);

    // Reset asserted mid-cycle while wr_en=100000; outputs clear before the next edge.
    drive(4'b0110, ADDR_N, DATA_N);
    #2;
    rstn = 1'b0;
    #1;
    check_outs("async_rst", 4'b0000, 4'b0000, 6'b000000, 4'h0, 2'd0, 1'b0);
    #1;
    rstn = 1'b1;
    step();
    check_outs("post_rst", 4'b0010, 4'b0000, 6'b000010, 4'h5, 2'd1, 1'b1);
    drive(4'b0000, ADDR_N, DATA_N);
    step();
    check_outs("post_rst_idle", 4'b0000, 4'b0000, 6'b000000, 4'h5, 2'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
